// File: rtl/rf_wport_arb.sv
// Write-port controller for the register file: clears x1..x31 after reset, then
// shares the single write port between pipeline writeback and a long-latency unit.
module rf_wport_arb #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          INIT_CLEAR   = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WB_EN,
    input  logic [4:0]  WB_NUM,
    input  logic [31:0] WB_DATA,
    input  logic        LU_VALID,
    output logic        LU_READY,
    input  logic [4:0]  LU_NUM,
    input  logic [31:0] LU_DATA,
    output logic [4:0]  WNUM,
    output logic [31:0] WDATA,
    output logic        PEND_VALID,
    output logic [4:0]  PEND_NUM,
    output logic        INIT_BUSY,
    output logic        STALL_REQ,
    output logic        ERR
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [4:0]  init_cnt_reg;
    logic        hold_valid_reg;
    logic [4:0]  hold_num_reg;
    logic [31:0] hold_data_reg;
    logic [3:0]  starve_cnt_reg;
    logic        stall_reg;
    logic        err_reg;

    logic run;
    logic wb_take;
    logic drain;
    logic cancel;
    logic lu_ready;
    logic lu_keep;
    logic hold_empties;

    always_comb begin
        run          = (state_reg == ST_RUN);
        wb_take      = run && WB_EN && (WB_NUM != 5'd0);
        drain        = run && !wb_take && hold_valid_reg;
        cancel       = run && wb_take && hold_valid_reg && (WB_NUM == hold_num_reg);
        hold_empties = drain || cancel;
        // Ready depends on this cycle's writeback so a draining hold can refill back-to-back.
        lu_ready     = run && !RST && (!hold_valid_reg || drain);
        // x0 targets and targets overwritten by the same-cycle writeback are acknowledged but dropped.
        lu_keep      = LU_VALID && lu_ready && (LU_NUM != 5'd0)
                       && !(wb_take && (LU_NUM == WB_NUM));
    end

    always_comb begin
        WNUM  = 5'd0;
        WDATA = 32'd0;
        if (!RST) begin
            if (state_reg == ST_INIT) begin
                WNUM = init_cnt_reg;
            end else if (wb_take) begin
                WNUM  = WB_NUM;
                WDATA = WB_DATA;
            end else if (hold_valid_reg) begin
                WNUM  = hold_num_reg;
                WDATA = hold_data_reg;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= INIT_CLEAR ? ST_INIT : ST_RUN;
            init_cnt_reg   <= 5'd1;
            hold_valid_reg <= 1'b0;
            hold_num_reg   <= 5'd0;
            hold_data_reg  <= 32'd0;
            starve_cnt_reg <= 4'd0;
            stall_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (WB_EN) begin
                        err_reg <= 1'b1;
                    end
                    init_cnt_reg <= init_cnt_reg + 5'd1;
                    if (init_cnt_reg == 5'd31) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stall_reg && wb_take) begin
                        err_reg <= 1'b1;
                    end
                    if (lu_keep) begin
                        hold_valid_reg <= 1'b1;
                        hold_num_reg   <= LU_NUM;
                        hold_data_reg  <= LU_DATA;
                    end else if (hold_empties) begin
                        hold_valid_reg <= 1'b0;
                    end
                    // Starvation is tracked per held entry; a fresh entry starts from zero.
                    if (!hold_valid_reg || hold_empties) begin
                        starve_cnt_reg <= 4'd0;
                        stall_reg      <= 1'b0;
                    end else if (wb_take) begin
                        if (starve_cnt_reg < LIMIT) begin
                            starve_cnt_reg <= starve_cnt_reg + 4'd1;
                        end
                        if (starve_cnt_reg >= LIMIT - 4'd1) begin
                            stall_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    assign LU_READY   = lu_ready;
    assign PEND_VALID = hold_valid_reg;
    assign PEND_NUM   = hold_num_reg;
    assign INIT_BUSY  = (state_reg == ST_INIT);
    assign STALL_REQ  = stall_reg;
    assign ERR        = err_reg;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Random-stimulus bench for rf_wport_arb against a queue-based reference model.
module tb_rf_wport_arb;

    localparam int LIMIT  = 4;
    localparam int CYCLES = 3000;

    logic        CLK;
    logic        RST;
    logic        WB_EN;
    logic [4:0]  WB_NUM;
    logic [31:0] WB_DATA;
    logic        LU_VALID;
    logic        LU_READY;
    logic [4:0]  LU_NUM;
    logic [31:0] LU_DATA;
    logic [4:0]  WNUM;
    logic [31:0] WDATA;
    logic        PEND_VALID;
    logic [4:0]  PEND_NUM;
    logic        INIT_BUSY;
    logic        STALL_REQ;
    logic        ERR;

    rf_wport_arb #(.STARVE_LIMIT(LIMIT), .INIT_CLEAR(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .WB_EN(WB_EN), .WB_NUM(WB_NUM), .WB_DATA(WB_DATA),
        .LU_VALID(LU_VALID), .LU_READY(LU_READY), .LU_NUM(LU_NUM), .LU_DATA(LU_DATA),
        .WNUM(WNUM), .WDATA(WDATA),
        .PEND_VALID(PEND_VALID), .PEND_NUM(PEND_NUM),
        .INIT_BUSY(INIT_BUSY), .STALL_REQ(STALL_REQ), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int n_stall = 0;
    int n_cancel = 0;
    int n_drain = 0;

    // Reference model state: cycles of clearing left, the hold as a queue, starvation bookkeeping.
    int          m_init_left;
    int          m_hold_num[$];
    logic [31:0] m_hold_data[$];
    int          m_starve;
    bit          m_stall;
    bit          m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_init_left = 31;
        m_hold_num.delete();
        m_hold_data.delete();
        m_starve = 0;
        m_stall  = 0;
        m_err    = 0;
    endtask

    task automatic check_cycle();
        bit          wb;
        logic [4:0]  e_num;
        logic [31:0] e_data;
        bit          e_ready;
        if (RST) begin
            check_eq("rst_wnum", 32'(WNUM), 32'd0);
            check_eq("rst_wdata", WDATA, 32'd0);
            check_eq("rst_ready", 32'(LU_READY), 32'd0);
            check_eq("rst_busy", 32'(INIT_BUSY), 32'd1);
            check_eq("rst_pend", 32'(PEND_VALID), 32'd0);
            check_eq("rst_stall", 32'(STALL_REQ), 32'd0);
            check_eq("rst_err", 32'(ERR), 32'd0);
            return;
        end
        wb = WB_EN && (WB_NUM != 0);
        e_num = 0;
        e_data = 0;
        e_ready = 0;
        if (m_init_left > 0) begin
            e_num = 5'(32 - m_init_left);
        end else begin
            e_ready = (m_hold_num.size() == 0) || !wb;
            if (wb) begin
                e_num = WB_NUM;
                e_data = WB_DATA;
            end else if (m_hold_num.size() > 0) begin
                e_num = 5'(m_hold_num[0]);
                e_data = m_hold_data[0];
            end
        end
        check_eq("wnum", 32'(WNUM), 32'(e_num));
        check_eq("wdata", WDATA, e_data);
        check_eq("lu_ready", 32'(LU_READY), 32'(e_ready));
        check_eq("init_busy", 32'(INIT_BUSY), 32'(m_init_left > 0));
        check_eq("pend_valid", 32'(PEND_VALID), 32'(m_hold_num.size() > 0));
        if (m_hold_num.size() > 0) check_eq("pend_num", 32'(PEND_NUM), 32'(m_hold_num[0]));
        check_eq("stall_req", 32'(STALL_REQ), 32'(m_stall));
        check_eq("err", 32'(ERR), 32'(m_err));
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        bit wb;
        bit acc;
        if (RST) return;
        wb = WB_EN && (WB_NUM != 0);
        if (m_init_left > 0) begin
            if (WB_EN) m_err = 1;
            m_init_left--;
            return;
        end
        if (m_stall && wb) m_err = 1;
        acc = LU_VALID && ((m_hold_num.size() == 0) || !wb);
        if (m_hold_num.size() > 0) begin
            if (!wb) begin
                n_drain++;
                void'(m_hold_num.pop_front());
                void'(m_hold_data.pop_front());
            end else if (WB_NUM == m_hold_num[0]) begin
                n_cancel++;
                void'(m_hold_num.pop_front());
                void'(m_hold_data.pop_front());
            end else begin
                m_starve++;
            end
        end
        if (m_hold_num.size() == 0) begin
            m_starve = 0;
            m_stall = 0;
        end else if (m_starve >= LIMIT) begin
            if (!m_stall) n_stall++;
            m_stall = 1;
        end
        if (acc && LU_NUM != 0 && !(wb && LU_NUM == WB_NUM)) begin
            m_hold_num.push_back(int'(LU_NUM));
            m_hold_data.push_back(LU_DATA);
        end
    endtask

    initial begin
        RST = 1'b1;
        WB_EN = 0; WB_NUM = 0; WB_DATA = 0;
        LU_VALID = 0; LU_NUM = 0; LU_DATA = 0;
        model_reset();
        @(negedge CLK);
        #1 check_cycle();
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge CLK);
            if (cyc == 0 || cyc == 11) RST = 1'b0;
            else if (cyc == 10) RST = 1'b1;
            else if (RST) RST = ($urandom_range(0, 1) == 0);
            else if (cyc > 40 && $urandom_range(0, 399) == 0) RST = 1'b1;
            if (RST) model_reset();

            if (m_init_left > 0 || RST) WB_EN = ($urandom_range(0, 19) == 0);
            else if (m_stall) WB_EN = ($urandom_range(0, 9) == 0);
            else WB_EN = ($urandom_range(0, 9) < 7);
            WB_NUM   = 5'($urandom_range(0, 7));
            WB_DATA  = $urandom;
            LU_VALID = ($urandom_range(0, 1) == 1);
            LU_NUM   = 5'($urandom_range(0, 7));
            LU_DATA  = $urandom;
            #1;
            check_cycle();
            model_step();
        end
        $display("coverage: stalls=%0d cancels=%0d drains=%0d", n_stall, n_cancel, n_drain);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
